// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master: FSM states,
// bus widths and the registered-output bundle.
package apb_cmd_master_pkg;

    localparam int APB_ADDR_W             = 2;
    localparam int APB_DATA_W             = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Every block output comes straight from one of these flops.
    typedef struct packed {
        logic                  cmd_ready;
        logic                  rsp_valid;
        logic                  rsp_err;
        logic [APB_DATA_W-1:0] rsp_rdata;
        logic                  psel;
        logic                  penable;
        logic                  pwrite;
        logic [APB_ADDR_W-1:0] paddr;
        logic [APB_DATA_W-1:0] pwdata;
    } out_t;

    localparam out_t OUT_RESET = '{cmd_ready: 1'b1, default: '0};

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response, APB and interrupt signals of the APB command master.
// The master modport is the block's view; slave is the environment's view.
interface apb_cmd_master_if;
    import apb_cmd_master_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [APB_ADDR_W-1:0] cmd_addr;
    logic [APB_DATA_W-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [APB_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  intr;
    logic                  irq_ack;
    logic                  irq_pending;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, intr, irq_ack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata, irq_pending
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, intr, irq_ack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata, irq_pending
    );

endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB master: one command in, one APB transfer, one response out.
// Optional ACCESS timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state_q, state_d;
    out_t   out_q, out_d;
    logic   timed_out;
    logic   intr_q;
    logic   irq_pending_q;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // NOTE: state lives in flops updated with <= so every process sees pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        timed_out = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d         = ST_SETUP;
                    out_d.cmd_ready = 1'b0;
                    out_d.psel      = 1'b1;
                    out_d.pwrite    = bus.cmd_write;
                    out_d.paddr     = bus.cmd_addr;
                    out_d.pwdata    = bus.cmd_wdata;
                end
            end
            ST_SETUP: begin
                state_d       = ST_ACCESS;
                out_d.penable = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                cnt_d         = '0;
`endif
            end
            ST_ACCESS: begin
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                if (!bus.pready) begin
                    timed_out = (cnt_q == CNT_LAST);
                    cnt_d     = cnt_q + 1'b1;
                end
`endif
                if (bus.pready || timed_out) begin
                    state_d         = ST_RESP;
                    out_d.psel      = 1'b0;
                    out_d.penable   = 1'b0;
                    out_d.pwrite    = 1'b0;
                    out_d.paddr     = '0;
                    out_d.pwdata    = '0;
                    out_d.rsp_valid = 1'b1;
                    out_d.rsp_err   = timed_out;
                    // Writes and aborted transfers report zero data.
                    out_d.rsp_rdata = (bus.pready && !out_q.pwrite) ? bus.prdata : '0;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d         = ST_IDLE;
                    out_d.rsp_valid = 1'b0;
                    out_d.cmd_ready = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = OUT_RESET;
            end
        endcase
    end

    // A rising edge of intr sets the flag even if irq_ack arrives in the same cycle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            intr_q        <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            intr_q <= bus.intr;
            if (bus.intr && !intr_q)  irq_pending_q <= 1'b1;
            else if (bus.irq_ack)     irq_pending_q <= 1'b0;
        end
    end

    assign bus.cmd_ready   = out_q.cmd_ready;
    assign bus.rsp_valid   = out_q.rsp_valid;
    assign bus.rsp_err     = out_q.rsp_err;
    assign bus.rsp_rdata   = out_q.rsp_rdata;
    assign bus.psel        = out_q.psel;
    assign bus.penable     = out_q.penable;
    assign bus.pwrite      = out_q.pwrite;
    assign bus.paddr       = out_q.paddr;
    assign bus.pwdata      = out_q.pwdata;
    assign bus.irq_pending = irq_pending_q;

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of ACCESS cycles waited for pready (used only with APB_CMD_MASTER_TIMEOUT_EN).
REQ-002 pclk  input  1  APB clock; all state on its rising edge.
REQ-003 preset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  input  1  1=write, 0=read.
REQ-007 cmd_addr  input  2  target register address.
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-011 rsp_rdata  output  8  read data (0 for writes).
REQ-012 rsp_err  output  1  transfer aborted by timeout.
REQ-013 psel, penable, pwrite  output  1 each  APB control to peripheral.
REQ-014 paddr  output  2; pwdata  output  8; prdata  input  8; pready  input  1  APB address/data/ready.
REQ-015 intr  input  1  peripheral interrupt; irq_ack  input  1  clear; irq_pending  output  1  sticky interrupt flag.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-017 IDLE: cmd_ready=1, psel=0, penable=0; on cmd_valid, latch cmd_write/cmd_addr/cmd_wdata -> SETUP.
REQ-018 SETUP (exactly one cycle): psel=1, penable=0, paddr/pwrite/pwdata driven from latched command -> ACCESS.
REQ-019 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable; stay while pready=0.
REQ-020 ACCESS with pready=1: capture prdata into rsp_rdata if read (0 if write), rsp_err=0 -> RESP; psel/penable drop next cycle.
REQ-021 RESP: rsp_valid=1, psel=0, penable=0, cmd_ready=0; rsp_rdata/rsp_err held until rsp_valid&&rsp_ready -> IDLE.
REQ-022 Minimum latency: command accepted at cycle N, SETUP N+1, ACCESS N+2, pready at N+2 gives rsp_valid at N+3.
REQ-023 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE is ignored (no queueing).
REQ-024 Back-to-back: rsp handshake in cycle M allows next accept in cycle M+1 at earliest.
REQ-025 pwdata and paddr SHALL be 0 in IDLE; pwrite 0 in IDLE.
REQ-026 irq_pending SHALL set on a 0->1 transition of intr (registered previous value), clear on irq_ack; set wins when both occur in the same cycle.

Reset
REQ-027 preset=1 SHALL asynchronously force IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, irq_pending=0, intr history=0, timeout counter=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no response; first accept possible in the first cycle after preset deasserts.

Configuration
REQ-029 Macro APB_CMD_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles; if pready still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, go RESP with rsp_err=1, rsp_rdata=0, psel/penable deasserted; counter clears on entering ACCESS.
REQ-030 Macro undefined: no counter, ACCESS waits indefinitely, rsp_err constantly 0.

Structure
REQ-031 Package apb_cmd_master_pkg SHALL hold the state enum typedef, APB_ADDR_W=2, APB_DATA_W=8 and default TIMEOUT_CYCLES constant.
REQ-032 No sub-module; single flat module, timeout counter inside the macro guard.

Verification
REQ-033 Write addr=2 data=0xA5, pready=1 in first ACCESS -> psel rises N+1, penable N+2, pwdata=0xA5 paddr=2 pwrite=1 stable; rsp_valid N+3, rsp_rdata=0, rsp_err=0.
REQ-034 Read addr=1, pready low 3 ACCESS cycles then high with prdata=0x3C -> rsp_rdata=0x3C, paddr stable throughout ACCESS.
REQ-035 rsp_ready held low 5 cycles with cmd_valid high -> cmd_ready=0, no new SETUP until handshake; next accept one cycle after it.
REQ-036 With APB_CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0.
REQ-037 preset asserted in ACCESS -> all outputs to reset values immediately, no rsp_valid afterward.
REQ-038 intr pulse 0->1 with simultaneous irq_ack -> irq_pending=1; irq_ack alone next cycle -> irq_pending=0; intr held high -> no re-set.
